pipe_sched: RTL

Round-robin scheduler sharing one fixed-latency datapath pipeline, built from single-register stages, among NREQ requesters. Each cycle it grants at most one requester, registers that requester's operand onto the pipeline input, and carries a valid/tag shadow alongside the datapath. When the result emerges LATENCY cycles later, it is steered back to the requester that issued it. The block sits between request sources and a shared arithmetic pipeline; the pipeline never stalls and responses are never back-pressured.

---
 rtl/pipe_sched.sv | 119 +++++++++++
 1 files changed

// File: rtl/pipe_sched.sv
// rtl/pipe_sched.sv - round-robin scheduler sharing one fixed-latency pipeline among requesters
module pipe_sched #(
   parameter int NREQ    = 4,
   parameter int WIDTH   = 8,
   parameter int LATENCY = 3,
   localparam int TAGW   = $clog2(NREQ),
   localparam int IFW    = $clog2(LATENCY + 2)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*WIDTH-1:0] req_data,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ-1:0]       enable,
   input  logic                  hold,
   output logic                  pipe_in_valid,
   output logic [WIDTH-1:0]      pipe_in_data,
   input  logic [WIDTH-1:0]      pipe_out_data,
   output logic [NREQ-1:0]       resp_valid,
   output logic [WIDTH-1:0]      resp_data,
   output logic [IFW-1:0]        in_flight,
   output logic                  idle
);

   logic [TAGW-1:0]  rr_ptr;
   logic [TAGW-1:0]  issue_tag;
   logic [TAGW-1:0]  gidx;
   logic             hs;
   logic [NREQ-1:0]  elig;
   logic [WIDTH-1:0] req_word [NREQ];
   logic [LATENCY-1:0] sh_valid;
   logic [TAGW-1:0]  sh_tag [LATENCY];
   logic             resp_any;

   // Unpack the flat operand bus into one word per requester
   for (genvar k = 0; k < NREQ; k++) begin : g_unpack
      assign req_word[k] = req_data[k*WIDTH +: WIDTH];
   end

   assign elig = hold ? '0 : (req_valid & enable);

   // Rotating priority search starting at rr_ptr; first eligible requester wins
   always_comb begin
      int idx;
      logic [TAGW-1:0] cand;
      req_ready = '0;
      gidx      = '0;
      hs        = 1'b0;
      idx       = 0;
      cand      = '0;
      for (int i = 0; i < NREQ; i++) begin
         idx = int'(rr_ptr) + i;
         if (idx >= NREQ) idx = idx - NREQ;
         cand = TAGW'(idx);
         if (!hs && elig[cand]) begin
            hs              = 1'b1;
            gidx            = cand;
            req_ready[cand] = 1'b1;
         end
      end
   end

   // Register the granted operand onto the pipeline input and advance the pointer
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr        <= '0;
         pipe_in_valid <= 1'b0;
         pipe_in_data  <= '0;
         issue_tag     <= '0;
      end else begin
         pipe_in_valid <= hs;
         if (hs) begin
            pipe_in_data <= req_word[gidx];
            issue_tag    <= gidx;
            rr_ptr       <= (gidx == TAGW'(NREQ - 1)) ? '0 : gidx + 1'b1;
         end
      end
   end

   // Valid/tag shadow that travels alongside the external datapath stages
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sh_valid <= '0;
         for (int i = 0; i < LATENCY; i++) sh_tag[i] <= '0;
      end else begin
         sh_valid[0] <= pipe_in_valid;
         sh_tag[0]   <= issue_tag;
         for (int i = 1; i < LATENCY; i++) begin
            sh_valid[i] <= sh_valid[i-1];
            sh_tag[i]   <= sh_tag[i-1];
         end
      end
   end

   assign resp_any  = sh_valid[LATENCY-1];
   assign resp_data = pipe_out_data;

   // Steer the emerging result back to the requester that issued it
   always_comb begin
      resp_valid = '0;
      if (resp_any) resp_valid[sh_tag[LATENCY-1]] = 1'b1;
   end

   // Outstanding-operation count; a grant and a retirement in one cycle cancel
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         in_flight <= '0;
      end else begin
         case ({hs, resp_any})
            2'b10:   in_flight <= in_flight + 1'b1;
            2'b01:   in_flight <= in_flight - 1'b1;
            default: in_flight <= in_flight;
         endcase
      end
   end

   assign idle = (in_flight == '0) && !pipe_in_valid;

endmodule
